window_7x7_gen: RTL and testbench

Converts a raster-order grayscale pixel stream into a sliding 7x7 neighbourhood, one window per accepted pixel once the window lies fully inside the image. It sits directly upstream of the 7x7 CI/binarisation stage and drives that stage's 49 pixel inputs. It also supplies the window's centre coordinate. Six line delays plus a 7x7 register array; no backpressure.

---
 rtl/window_7x7_gen_pkg.sv | 17 +
 rtl/line_delay.sv | 39 +++
 rtl/window_7x7_gen.sv | 117 +++++++++++
 tb/tb_window_7x7_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/window_7x7_gen_pkg.sv
// Shared constants for the 7x7 window generator and the stages it feeds.
// WIN_SIZE/WIN_RADIUS/WIN_ELEMS describe the square neighbourhood.
// idx(r,c) maps a window row/column to its element index in the flat bus.
package window_7x7_gen_pkg;

  localparam int WIN_SIZE    = 7;
  localparam int WIN_RADIUS  = 3;
  localparam int WIN_ELEMS   = 49;
  localparam int LINE_DELAYS = WIN_SIZE - 1;

  // Element index inside o_window: row 0 is the oldest line, column 0 the
  // oldest column.
  function automatic int idx(input int r, input int c);
    return r * WIN_SIZE + c;
  endfunction

endpackage

// File: rtl/line_delay.sv
// Enable-gated delay line: o_dout is the sample written DEPTH enables ago.
// Ports:
//   i_clk   clock, rising edge
//   i_rst_n asynchronous active-low reset (address pointer only)
//   i_en    advance strobe; i_din is written on every cycle with i_en=1
//   i_din   sample in
//   o_dout  sample written DEPTH accepted cycles earlier (combinational read)
module line_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    addr;

  // Reading the slot about to be overwritten yields exactly DEPTH of delay.
  assign o_dout = mem[addr];

  always_ff @(posedge i_clk) begin
    if (i_en) mem[addr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr <= '0;
    end else if (i_en) begin
      addr <= (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/window_7x7_gen.sv
// Sliding 7x7 neighbourhood generator for a raster-order pixel stream.
// Ports:
//   i_clk, i_rst_n  clock (rising edge), asynchronous active-low reset
//   i_valid         pixel strobe, every strobed pixel is accepted
//   i_sof           start of frame, forces the accepted pixel to (0,0)
//   i_pixel         input pixel
//   o_valid         window/coordinates valid (one cycle after the accept)
//   o_window        49 elements, element r*7+c at [(r*7+c)*WIDTH +: WIDTH]
//   o_x, o_y        centre coordinate of the window
//   o_frame_done    pulses with the last valid window of a frame
module window_7x7_gen
  import window_7x7_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic                       i_sof,
  input  logic [WIDTH-1:0]           i_pixel,
  output logic                       o_valid,
  output logic [WIN_ELEMS*WIDTH-1:0] o_window,
  output logic [$clog2(IMG_W)-1:0]   o_x,
  output logic [$clog2(IMG_H)-1:0]   o_y,
  output logic                       o_frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0]    x_q, cur_x_p0;
  logic [YW-1:0]    y_q, cur_y_p0;
  logic [WIDTH-1:0] ld_in  [LINE_DELAYS];
  logic [WIDTH-1:0] ld_out [LINE_DELAYS];
  logic [WIDTH-1:0] col_p0 [WIN_SIZE];
  logic             win_ok_p0;
  logic             last_p0;
  logic [WIN_ELEMS*WIDTH-1:0] win_p1;
  logic             vld_p1;

  // A strobed start-of-frame overrides whatever the counters hold.
  assign cur_x_p0  = (i_valid && i_sof) ? '0 : x_q;
  assign cur_y_p0  = (i_valid && i_sof) ? '0 : y_q;
  assign win_ok_p0 = (cur_x_p0 >= XW'(WIN_SIZE - 1)) && (cur_y_p0 >= YW'(WIN_SIZE - 1));
  assign last_p0   = (cur_x_p0 == XW'(IMG_W - 1)) && (cur_y_p0 == YW'(IMG_H - 1));

  genvar k;
  generate
    for (k = 0; k < LINE_DELAYS; k++) begin : g_ld
      if (k == 0) begin : g_first
        assign ld_in[k] = i_pixel;
      end else begin : g_chain
        assign ld_in[k] = ld_out[k-1];
      end
      line_delay #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_line_delay (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (i_valid),
        .i_din  (ld_in[k]),
        .o_dout (ld_out[k])
      );
    end
  endgenerate

  // Incoming column: bottom row is the live pixel, each row above is one
  // more line delay back.
  always_comb begin
    for (int r = 0; r < WIN_SIZE; r++) col_p0[r] = '0;
    col_p0[WIN_SIZE-1] = i_pixel;
    for (int r = 0; r < WIN_SIZE - 1; r++) col_p0[r] = ld_out[WIN_SIZE-2-r];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (i_valid) begin
      if (cur_x_p0 == XW'(IMG_W - 1)) begin
        x_q <= '0;
        y_q <= (cur_y_p0 == YW'(IMG_H - 1)) ? '0 : cur_y_p0 + 1'b1;
      end else begin
        x_q <= cur_x_p0 + 1'b1;
        y_q <= cur_y_p0;
      end
    end
  end

  // ---- stage p0 -> p1: window shift and registered outputs ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_p1       <= '0;
      vld_p1       <= 1'b0;
      o_x          <= '0;
      o_y          <= '0;
      o_frame_done <= 1'b0;
    end else begin
      vld_p1       <= i_valid && win_ok_p0;
      o_frame_done <= i_valid && win_ok_p0 && last_p0;
      if (i_valid) begin
        for (int r = 0; r < WIN_SIZE; r++) begin
          for (int c = 0; c < WIN_SIZE - 1; c++) begin
            win_p1[idx(r, c)*WIDTH +: WIDTH] <= win_p1[idx(r, c + 1)*WIDTH +: WIDTH];
          end
          win_p1[idx(r, WIN_SIZE - 1)*WIDTH +: WIDTH] <= col_p0[r];
        end
        o_x <= cur_x_p0 - XW'(WIN_RADIUS);
        o_y <= cur_y_p0 - YW'(WIN_RADIUS);
      end
    end
  end

  assign o_valid  = vld_p1;
  assign o_window = win_p1;

endmodule

// File: tb/tb_window_7x7_gen.sv
module tb_window_7x7_gen;

  localparam int W  = 8;
  localparam int IW = 16;
  localparam int IH = 10;
  localparam int NPIX = IW * IH;

  typedef logic [400:0] rec_t;  // {frame_done, y[3:0], x[3:0], window[391:0]}

  logic           clk = 1'b0;
  logic           rst_n;
  logic           valid, sof;
  logic [W-1:0]   pixel;
  logic           o_valid, o_frame_done;
  logic [391:0]   o_window;
  logic [3:0]     o_x, o_y;

  int n_pass   = 0;
  int n_checks = 0;

  logic [7:0] img [IH][IW];
  int   mx = 0, my = 0;
  rec_t caps[$];
  rec_t ref_q[$];

  always #5 clk = ~clk;

  window_7x7_gen #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_sof       (sof),
    .i_pixel     (pixel),
    .o_valid     (o_valid),
    .o_window    (o_window),
    .o_x         (o_x),
    .o_y         (o_y),
    .o_frame_done(o_frame_done)
  );

  task automatic chk(input string tag, input logic [400:0] obs, input logic [400:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive, wait for the edge, then check against the image model.
  task automatic cyc(input bit v, input bit s, input logic [7:0] p);
    logic         ev, efd;
    logic [391:0] ew;
    int           ex, ey;
    valid = v; sof = s; pixel = p;
    @(posedge clk);
    #1;
    ev = 1'b0; efd = 1'b0; ew = '0; ex = 0; ey = 0;
    if (v) begin
      if (s) begin mx = 0; my = 0; end
      img[my][mx] = p;
      ev = (mx >= 6) && (my >= 6);
      if (ev) begin
        for (int r = 0; r < 7; r++)
          for (int c = 0; c < 7; c++)
            ew[(r*7+c)*8 +: 8] = img[my-6+r][mx-6+c];
        ex  = mx - 3;
        ey  = my - 3;
        efd = (mx == IW-1) && (my == IH-1);
      end
      mx = mx + 1;
      if (mx == IW) begin mx = 0; my = (my == IH-1) ? 0 : my + 1; end
    end
    chk("o_valid", 401'(o_valid), 401'(ev));
    if (ev) begin
      chk("o_window", 401'(o_window), 401'(ew));
      chk("o_x", 401'(o_x), 401'(ex));
      chk("o_y", 401'(o_y), 401'(ey));
      chk("o_frame_done", 401'(o_frame_done), 401'(efd));
      caps.push_back({o_frame_done, o_y, o_x, o_window});
    end else begin
      chk("o_frame_done_idle", 401'(o_frame_done), 401'(0));
    end
  endtask

  // ramp: pixel = (y*16+x)&0xFF, else random pixels; gaps: random idle cycles.
  task automatic send_frame(input bit ramp, input bit gaps, input bit use_sof, input int npix);
    logic [7:0] p;
    caps.delete();
    for (int i = 0; i < npix; i++) begin
      if (gaps) while ($urandom_range(1, 0) == 1) cyc(1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
      p = ramp ? 8'(i) : 8'($urandom);
      cyc(1'b1, use_sof && (i == 0), p);
    end
  endtask

  task automatic cmp_caps(input string tag);
    int n;
    chk({tag, "_count"}, 401'(caps.size()), 401'(ref_q.size()));
    n = (caps.size() < ref_q.size()) ? caps.size() : ref_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_win"}, caps[i], ref_q[i]);
  endtask

  initial begin
    rec_t r0;
    rst_n = 1'b0; valid = 1'b0; sof = 1'b0; pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 401'(o_valid), 401'(0));
    chk("rst_window", 401'(o_window), 401'(0));
    chk("rst_xy", 401'({o_y, o_x}), 401'(0));
    chk("rst_fd", 401'(o_frame_done), 401'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Gap-free ramp frame: reference sequence plus directed values.
    send_frame(1'b1, 1'b0, 1'b1, NPIX);
    ref_q = caps;
    chk("ramp_count", 401'(ref_q.size()), 401'(40));
    if (ref_q.size() == 40) begin
      r0 = ref_q[0];
      chk("first_e0", 401'(r0[0 +: 8]), 401'(0));
      chk("first_e48", 401'(r0[48*8 +: 8]), 401'(102));
      chk("first_e24", 401'(r0[24*8 +: 8]), 401'(51));
      chk("first_xy", 401'(r0[399:392]), 401'({4'd3, 4'd3}));
      r0 = ref_q[10];
      chk("line7_xy", 401'(r0[399:392]), 401'({4'd4, 4'd3}));
      chk("line7_e0", 401'(r0[0 +: 8]), 401'(16));
      r0 = ref_q[39];
      chk("last_xy", 401'(r0[399:392]), 401'({4'd6, 4'd12}));
      chk("last_fd", 401'(r0[400]), 401'(1));
    end

    // Back-to-back second frame, no sof: counters must have wrapped.
    send_frame(1'b1, 1'b0, 1'b0, NPIX);
    cmp_caps("frame2");

    // Same ramp with random idle cycles.
    send_frame(1'b1, 1'b1, 1'b1, NPIX);
    cmp_caps("gapped");

    // Partial frame up to (4,8), then resync with sof.
    send_frame(1'b1, 1'b0, 1'b1, 8*IW + 5);
    send_frame(1'b1, 1'b0, 1'b1, NPIX);
    cmp_caps("sof_resync");
    if (caps.size() > 0) begin
      r0 = caps[0];
      chk("sof_e48", 401'(r0[48*8 +: 8]), 401'(102));
    end

    // Random pixel frames with random gaps.
    send_frame(1'b0, 1'b1, 1'b1, NPIX);
    send_frame(1'b0, 1'b1, 1'b1, NPIX);

    // Async reset between edges right after a valid window.
    send_frame(1'b1, 1'b0, 1'b1, 7*IW + 9);
    chk("pre_rst_valid", 401'(o_valid), 401'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 401'(o_valid), 401'(0));
    chk("arst_window", 401'(o_window), 401'(0));
    chk("arst_xy", 401'({o_y, o_x}), 401'(0));
    chk("arst_fd", 401'(o_frame_done), 401'(0));
    mx = 0; my = 0;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1'b1, 1'b0, 1'b0, NPIX);
    cmp_caps("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
